// File: rtl/shift_pipe_pkg.sv
// Shared op codes and carry helper for the pipelined shifter.
// The low two op codes keep the legacy 2-bit aluc encoding.
package shift_pkg;

   localparam logic [2:0] OP_SRA  = 3'b000;
   localparam logic [2:0] OP_SRL  = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SLL2 = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;

   // Last bit shifted out, taken from the unshifted operand; sized for the widest build.
   function automatic logic carry_out(input logic [63:0] a,
                                      input logic [6:0]  width,
                                      input logic [6:0]  n,
                                      input logic [2:0]  op);
      logic [5:0] lo_idx;
      logic [5:0] hi_idx;
      logic       c;
      lo_idx = 6'(n - 7'd1);
      hi_idx = 6'(width - n);
      c      = 1'b0;
      if (n == 7'd0) begin
         c = 1'b0;
      end else begin
         case (op)
            OP_SRA, OP_SRL, OP_ROR:  c = a[lo_idx];
            OP_SLL, OP_SLL2, OP_ROL: c = a[hi_idx];
            default:                 c = 1'b0;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One registered mux level of the shifter: shifts or rotates by 2**STAGE_K
// when its shamt bit is set, and carries the operation's sideband along.
module shift_stage
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TAG_W   = 4,
   parameter int STAGE_K = 0,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               dn_en,
   input  logic               d_valid,
   input  logic [WIDTH-1:0]   d_data,
   input  logic [SHAMT_W-1:0] d_shamt,
   input  logic [2:0]         d_op,
   input  logic [TAG_W-1:0]   d_tag,
   input  logic               d_carry,
   output logic               q_valid,
   output logic [WIDTH-1:0]   q_data,
   output logic [SHAMT_W-1:0] q_shamt,
   output logic [2:0]         q_op,
   output logic [TAG_W-1:0]   q_tag,
   output logic               q_carry
);

   localparam int SH = 2 ** STAGE_K;

   logic               valid_r;
   logic [WIDTH-1:0]   data_r;
   logic [SHAMT_W-1:0] shamt_r;
   logic [2:0]         op_r;
   logic [TAG_W-1:0]   tag_r;
   logic               carry_r;
   logic [WIDTH-1:0]   level_s;
   logic               en_s;

   // Stage input is already shifted by the lower levels, so its MSB is the original sign.
   always_comb begin
      level_s = d_data;
      if (d_shamt[STAGE_K]) begin
         case (d_op)
            OP_SRA:          level_s = {{SH{d_data[WIDTH-1]}}, d_data[WIDTH-1:SH]};
            OP_SRL:          level_s = {{SH{1'b0}}, d_data[WIDTH-1:SH]};
            OP_SLL, OP_SLL2: level_s = {d_data[WIDTH-1-SH:0], {SH{1'b0}}};
            OP_ROR:          level_s = {d_data[SH-1:0], d_data[WIDTH-1:SH]};
            OP_ROL:          level_s = {d_data[WIDTH-1-SH:0], d_data[WIDTH-1:WIDTH-SH]};
            default:         level_s = d_data;
         endcase
      end else begin
         level_s = d_data;
      end
   end

   assign en_s = ~valid_r | dn_en;

   // Pipeline register; flush wins over a load, bubbles load with valid low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= 1'b0;
         data_r  <= {WIDTH{1'b0}};
         shamt_r <= {SHAMT_W{1'b0}};
         op_r    <= 3'b000;
         tag_r   <= {TAG_W{1'b0}};
         carry_r <= 1'b0;
      end else if (flush) begin
         valid_r <= 1'b0;
      end else if (en_s) begin
         valid_r <= d_valid;
         data_r  <= level_s;
         shamt_r <= d_shamt;
         op_r    <= d_op;
         tag_r   <= d_tag;
         carry_r <= d_carry;
      end
   end

   assign q_valid = valid_r;
   assign q_data  = data_r;
   assign q_shamt = shamt_r;
   assign q_op    = op_r;
   assign q_tag   = tag_r;
   assign q_carry = carry_r;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator: one registered mux level per shamt bit,
// valid/ready handshake with backpressure and synchronous flush.
module shift_pipe
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int TAG_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [2:0]         in_op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_carry,
   output logic               out_zero,
   output logic [TAG_W-1:0]   out_tag
);

   logic [SHAMT_W:0]   valid_s;
   logic [SHAMT_W:0]   carry_s;
   logic [SHAMT_W:0]   room_s;
   logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
   logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
   logic [2:0]         op_s    [SHAMT_W+1];
   logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];
   logic               unused_s;

   assign valid_s[0] = in_valid;
   assign data_s[0]  = in_a;
   assign shamt_s[0] = in_shamt;
   assign op_s[0]    = in_op;
   assign tag_s[0]   = in_tag;
   assign carry_s[0] = carry_out(64'(in_a), 7'(WIDTH), 7'(in_shamt), in_op);

   // room_s[k] is the load enable of stage k: unrolled from en_k = !valid_k | en_(k+1)
   // so the ready chain is built from register outputs only.
   assign room_s[SHAMT_W] = out_ready;

   generate
      for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
         assign room_s[k] = out_ready | ~(&valid_s[SHAMT_W:k+1]);

         shift_stage #(
            .WIDTH   (WIDTH),
            .TAG_W   (TAG_W),
            .STAGE_K (k),
            .SHAMT_W (SHAMT_W)
         ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush   (flush),
            .dn_en   (room_s[k+1]),
            .d_valid (valid_s[k]),
            .d_data  (data_s[k]),
            .d_shamt (shamt_s[k]),
            .d_op    (op_s[k]),
            .d_tag   (tag_s[k]),
            .d_carry (carry_s[k]),
            .q_valid (valid_s[k+1]),
            .q_data  (data_s[k+1]),
            .q_shamt (shamt_s[k+1]),
            .q_op    (op_s[k+1]),
            .q_tag   (tag_s[k+1]),
            .q_carry (carry_s[k+1])
         );
      end
   endgenerate

   // A flushed cycle still consumes (and drops) whatever is presented.
   assign in_ready  = room_s[0] | flush;
   assign out_valid = valid_s[SHAMT_W];
   assign out_data  = data_s[SHAMT_W];
   assign out_carry = carry_s[SHAMT_W];
   assign out_tag   = tag_s[SHAMT_W];
   assign out_zero  = (data_s[SHAMT_W] == {WIDTH{1'b0}});

   assign unused_s = ^{shamt_s[SHAMT_W], op_s[SHAMT_W]};

endmodule
